// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ADD/SLL ALU, EX/WB register and saturating retire counter.
// Optional macro FWD_EN enables forwarding from the EX/WB register; otherwise fwd_a/fwd_b are 0.
module ex_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] reg_out_1,
    input  logic [DATA_W-1:0] reg_out_2,
    input  logic [DATA_W-1:0] shamt,
    input  logic              alu_sel,
    input  logic              alu_src,
    input  logic              regwrite,
    input  logic [REG_AW-1:0] write_reg,
    input  logic [REG_AW-1:0] source1,
    input  logic [REG_AW-1:0] source2,
    output logic [DATA_W-1:0] alu_result,
    output logic [REG_AW-1:0] write_reg_out,
    output logic              regwrite_out,
    output logic              zero,
    output logic              carry,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [CNT_W-1:0]  retire_count
);

    logic [DATA_W-1:0] alu_result_q, result_d;
    logic [REG_AW-1:0] write_reg_q;
    logic              regwrite_q, zero_q, carry_q, carry_d;
    logic [CNT_W-1:0]  retire_count_q;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W:0]   sum;

`ifdef FWD_EN
    assign fwd_a = regwrite_q && (write_reg_q == source1);
    assign fwd_b = regwrite_q && (write_reg_q == source2) && !alu_src;
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    assign op_a = fwd_a ? alu_result_q : reg_out_1;
    assign op_b = alu_src ? shamt : (fwd_b ? alu_result_q : reg_out_2);
    assign sum  = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        if (alu_sel) begin
            // Shift amounts of DATA_W or more clear the result.
            if (op_b < DATA_W[DATA_W-1:0]) begin
                result_d = op_a << op_b;
            end
        end else begin
            result_d = sum[DATA_W-1:0];
            carry_d  = sum[DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result_q   <= '0;
            write_reg_q    <= '0;
            regwrite_q     <= 1'b0;
            zero_q         <= 1'b0;
            carry_q        <= 1'b0;
            retire_count_q <= '0;
        end else begin
            alu_result_q <= result_d;
            write_reg_q  <= write_reg;
            regwrite_q   <= regwrite;
            zero_q       <= (result_d == '0);
            carry_q      <= carry_d;
            if (regwrite && (retire_count_q != '1)) begin
                retire_count_q <= retire_count_q + 1'b1;
            end
        end
    end

    assign alu_result    = alu_result_q;
    assign write_reg_out = write_reg_q;
    assign regwrite_out  = regwrite_q;
    assign zero          = zero_q;
    assign carry         = carry_q;
    assign retire_count  = retire_count_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a reference model pushes expected EX/WB contents per instruction.
module tb_ex_stage;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  res;
        logic [2:0]  wr;
        logic        rw;
        logic        z;
        logic        c;
        logic [15:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] reg_out_1, reg_out_2, shamt;
    logic       alu_sel, alu_src, regwrite;
    logic [2:0] write_reg, source1, source2;
    logic [7:0] alu_result;
    logic [2:0] write_reg_out;
    logic       regwrite_out, zero, carry, fwd_a, fwd_b;
    logic [15:0] retire_count;

    int errors = 0;
    int checks = 0;
    exp_t sb_q[$];

    // Reference model of the EX/WB register contents
    logic [7:0]  m_res;
    logic [2:0]  m_wr;
    logic        m_rw, m_z, m_c;
    logic [15:0] m_cnt;

    ex_stage dut (
        .clk           (clk),
        .reset         (reset),
        .reg_out_1     (reg_out_1),
        .reg_out_2     (reg_out_2),
        .shamt         (shamt),
        .alu_sel       (alu_sel),
        .alu_src       (alu_src),
        .regwrite      (regwrite),
        .write_reg     (write_reg),
        .source1       (source1),
        .source2       (source2),
        .alu_result    (alu_result),
        .write_reg_out (write_reg_out),
        .regwrite_out  (regwrite_out),
        .zero          (zero),
        .carry         (carry),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_res = '0; m_wr = '0; m_rw = 1'b0; m_z = 1'b0; m_c = 1'b0; m_cnt = '0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".res"}, {24'd0, alu_result}, 32'd0);
        check({tag, ".wr"},  {29'd0, write_reg_out}, 32'd0);
        check({tag, ".flags"}, {28'd0, regwrite_out, zero, carry, fwd_a | fwd_b}, 32'd0);
        check({tag, ".cnt"}, {16'd0, retire_count}, 32'd0);
    endtask

    // Called one step after an edge: drives one instruction, checks forwarding,
    // clocks it through and compares the EX/WB register against the scoreboard.
    task automatic step(input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] sh,
                        input logic sel, input logic src, input logic rw,
                        input logic [2:0] wr, input logic [2:0] s1, input logic [2:0] s2,
                        input bit quiet);
        logic       efa, efb;
        logic [7:0] a, b, res;
        logic       c;
        exp_t       e;
        reg_out_1 = r1; reg_out_2 = r2; shamt = sh; alu_sel = sel; alu_src = src;
        regwrite = rw; write_reg = wr; source1 = s1; source2 = s2;
        efa = FWD && m_rw && (m_wr == s1);
        efb = FWD && m_rw && (m_wr == s2) && !src;
        a = efa ? m_res : r1;
        b = src ? sh : (efb ? m_res : r2);
        if (sel) begin
            res = (b >= 8'd8) ? 8'h00 : 8'(a << b[2:0]);
            c = 1'b0;
        end else begin
            {c, res} = {1'b0, a} + {1'b0, b};
        end
        m_res = res; m_wr = wr; m_rw = rw; m_c = c; m_z = (res == 8'h00);
        if (rw && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (!quiet) sb_q.push_back('{res: m_res, wr: m_wr, rw: m_rw, z: m_z, c: m_c, cnt: m_cnt});
        #1;
        if (!quiet) begin
            check("fwd_a", {31'd0, fwd_a}, {31'd0, efa});
            check("fwd_b", {31'd0, fwd_b}, {31'd0, efb});
        end
        @(posedge clk);
        #1;
        if (!quiet) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("alu_result", {24'd0, alu_result}, {24'd0, e.res});
                check("write_reg_out", {29'd0, write_reg_out}, {29'd0, e.wr});
                check("regwrite_out", {31'd0, regwrite_out}, {31'd0, e.rw});
                check("zero", {31'd0, zero}, {31'd0, e.z});
                check("carry", {31'd0, carry}, {31'd0, e.c});
                check("retire_count", {16'd0, retire_count}, {16'd0, e.cnt});
            end
        end
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        // Reset held with random inputs: nothing loads
        for (int i = 0; i < 4; i++) begin
            reg_out_1 = 8'($urandom); reg_out_2 = 8'($urandom); shamt = 8'($urandom);
            alu_sel = 1'($urandom); alu_src = 1'($urandom); regwrite = 1'b1;
            write_reg = 3'($urandom); source1 = 3'($urandom); source2 = 3'($urandom);
            @(posedge clk);
            #1;
        end
        check_cleared("reset_hold");
        reset = 1'b1;

        // ADD overflow, first instruction after release
        step(8'h7F, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 3'd1, 1'b0);
        check("ovf.res", {24'd0, alu_result}, 32'h00);
        check("ovf.zc", {30'd0, zero, carry}, 32'd3);
        check("ovf.cnt", {16'd0, retire_count}, 32'd1);

        // Back-to-back dependency
        step(8'h05, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 3'd5, 3'd6, 1'b0);
        step(8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 3'd2, 3'd7, 1'b0);
        check("dep.res", {24'd0, alu_result}, FWD ? 32'h09 : 32'h01);

        // Shifts
        step(8'h03, 8'h00, 8'h02, 1'b1, 1'b1, 1'b1, 3'd6, 3'd1, 3'd1, 1'b0);
        check("sll2", {24'd0, alu_result}, 32'h0C);
        step(8'h03, 8'h00, 8'h08, 1'b1, 1'b1, 1'b1, 3'd6, 3'd1, 3'd1, 1'b0);
        check("sll8", {23'd0, alu_result, zero}, 32'h001);

        // Immediate blocks B forwarding; bubble never forwards
        step(8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 3'd0, 1'b0);
        step(8'h01, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 3'd1, 3'd0, 3'd4, 1'b0);
        check("imm.res", {24'd0, alu_result}, 32'h02);
        step(8'h33, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 3'd0, 1'b0);
        step(8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 3'd4, 3'd4, 1'b0);
        check("bubble.res", {24'd0, alu_result}, 32'h02);

        // Random stream, narrow register range to provoke dependencies
        for (int i = 0; i < 200; i++) begin
            step(8'($urandom), 8'($urandom), 8'($urandom_range(0, 10)), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 2)),
                 3'($urandom_range(0, 2)), 3'($urandom_range(0, 2)), 1'b0);
        end

        // Asynchronous reset between edges
        step(8'h21, 8'h22, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 3'd3, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_cleared("async_rst");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        step(8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 1'b0);
        check("post_rst.res", {24'd0, alu_result}, 32'h33);

        // Counter saturation: preload to 0xFFFE, then three more
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
        for (int i = 0; i < 16'hFFFE; i++) begin
            step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 3'd1, 1'b1);
        end
        check("preload.cnt", {16'd0, retire_count}, 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step(8'h01, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 3'd5, 3'd1, 3'd1, 1'b0);
        end
        check("sat.cnt", {16'd0, retire_count}, 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
